my_dff_debounce_bank: RTL

- Parametrised multi-channel successor to the single D flip-flop used on lock keypad/switch inputs.
- Per channel:
  - N-stage flip-flop synchroniser,
  - consecutive-cycle debounce filter,
  - registered stable output with one-cycle rise/fall pulses.
- Sits between raw board buttons/switches and the lock FSM, which consumes only the clean levels and pulses.

---
 rtl/my_dff_debounce_bank.sv | 63 ++++++
 1 files changed

// File: rtl/my_dff_debounce_bank.sv
// Per-channel synchroniser + consecutive-cycle debounce with registered level and rise/fall pulses.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges from a steady D change; free-running, no backpressure.
module my_dff_debounce_bank #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             DFF_CLOCK,
  input  logic             DFF_RESET_N,
  input  logic             DFF_ENABLE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync_s;
  logic [WIDTH-1:0][CW-1:0]          cnt;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchronisers shift every edge, independent of the filter enable.
  always_ff @(posedge DFF_CLOCK or negedge DFF_RESET_N) begin
    if (!DFF_RESET_N) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= D;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  always_ff @(posedge DFF_CLOCK or negedge DFF_RESET_N) begin
    if (!DFF_RESET_N) begin
      cnt  <= '0;
      Q    <= '0;
      RISE <= '0;
      FALL <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        RISE[i] <= 1'b0;
        FALL[i] <= 1'b0;
        if (!DFF_ENABLE || (sync_s[i] == Q[i])) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          // Disagreement held for the full window: commit the new level.
          cnt[i]  <= '0;
          Q[i]    <= sync_s[i];
          RISE[i] <= sync_s[i];
          FALL[i] <= ~sync_s[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

endmodule
